// File: rtl/sync_singles_filt.sv
`timescale 1ns/1ps
// sync_singles_filt
// Multi-channel single-bit input conditioner. Each asynchronous channel goes
// through a flop synchronizer, a consecutive-cycle glitch filter and rise/fall
// edge detection with a sticky rise flag. The filtered levels are presented
// zero-extended on a 32-bit status word for register readback.
module sync_singles_filt #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               FILTER_LEN  = 4,
    parameter logic [WIDTH-1:0] INIT_VAL    = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] sticky_clr,
    output logic [31:0]      out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] sticky_rise
);

    // FILTER_LEN = 1 still needs a 1-bit counter so the vector is legal; it
    // simply never leaves 0 because CNT_MAX is 0.
    localparam int             CW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_LEN - 1);

    (* ASYNC_REG = "TRUE" *) logic [1:0] rst_bridge_r;
    logic                                rst_int_n_s;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
    logic [WIDTH-1:0]                                           s_s;

    logic [WIDTH-1:0]          level_r;
    logic [WIDTH-1:0][CW-1:0]  cnt_r;
    logic [WIDTH-1:0]          rise_r;
    logic [WIDTH-1:0]          fall_r;
    logic [WIDTH-1:0]          sticky_r;

    logic [WIDTH-1:0]          level_nxt_s;
    logic [WIDTH-1:0][CW-1:0]  cnt_nxt_s;
    logic [WIDTH-1:0]          rise_nxt_s;
    logic [WIDTH-1:0]          fall_nxt_s;
    logic [WIDTH-1:0]          sticky_nxt_s;

    // Reset bridge: assertion is immediate, release is aligned to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_bridge_r <= 2'b00;
        end else begin
            rst_bridge_r <= {rst_bridge_r[0], 1'b1};
        end
    end

    assign rst_int_n_s = rst_bridge_r[1];

    // Synchronizer chain: only the first stage ever samples the raw inputs.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            sync_r <= {SYNC_STAGES{INIT_VAL}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], in};
        end
    end

    assign s_s = sync_r[SYNC_STAGES-1];

    // Filter, edge and sticky next-state: a level is accepted only after
    // FILTER_LEN consecutive disagreeing samples; any agreeing sample restarts.
    always_comb begin
        level_nxt_s = level_r;
        cnt_nxt_s   = cnt_r;
        rise_nxt_s  = '0;
        fall_nxt_s  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s_s[i] == level_r[i]) begin
                cnt_nxt_s[i] = '0;
            end else if (cnt_r[i] == CNT_MAX) begin
                level_nxt_s[i] = s_s[i];
                cnt_nxt_s[i]   = '0;
                rise_nxt_s[i]  = s_s[i];
                fall_nxt_s[i]  = ~s_s[i];
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CW'(1);
            end
        end
        // A new rise beats a simultaneous clear.
        sticky_nxt_s = rise_nxt_s | (sticky_r & ~sticky_clr);
    end

    // Filter state, edge pulses and sticky flags; pulses land on the same edge
    // as the level change they report.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            level_r  <= INIT_VAL;
            cnt_r    <= '0;
            rise_r   <= '0;
            fall_r   <= '0;
            sticky_r <= '0;
        end else begin
            level_r  <= level_nxt_s;
            cnt_r    <= cnt_nxt_s;
            rise_r   <= rise_nxt_s;
            fall_r   <= fall_nxt_s;
            sticky_r <= sticky_nxt_s;
        end
    end

    assign out         = 32'(level_r);
    assign rise        = rise_r;
    assign fall        = fall_r;
    assign sticky_rise = sticky_r;

endmodule

// File: tb/tb_sync_singles_filt.sv
`timescale 1ns/1ps
// tb_sync_singles_filt
// Directed bench: a default 8-channel instance (SYNC=2, FILTER=4) plus
// WIDTH=1 and WIDTH=32 instances with SYNC=8, FILTER=1. Edge j=0 is the first
// edge at which the synchronizer captures after the reset bridge releases.
module tb_sync_singles_filt;

    logic        clk;
    logic        rst_n;

    logic [7:0]  in_m, clr_m, rise_m, fall_m, sticky_m;
    logic [31:0] out_m;

    logic        in_a, clr_a, rise_a, fall_a, sticky_a;
    logic [31:0] out_a;

    logic [31:0] in_b, clr_b, rise_b, fall_b, sticky_b;
    logic [31:0] out_b;

    int n_cmp = 0;
    int n_err = 0;

    sync_singles_filt #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_LEN(4), .INIT_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .in(in_m), .sticky_clr(clr_m),
        .out(out_m), .rise(rise_m), .fall(fall_m), .sticky_rise(sticky_m));

    sync_singles_filt #(.WIDTH(1), .SYNC_STAGES(8), .FILTER_LEN(1), .INIT_VAL(1'b0)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .in(in_a), .sticky_clr(clr_a),
        .out(out_a), .rise(rise_a), .fall(fall_a), .sticky_rise(sticky_a));

    sync_singles_filt #(.WIDTH(32), .SYNC_STAGES(8), .FILTER_LEN(1), .INIT_VAL(32'hFFFF_0000)) dut_w32 (
        .clk(clk), .rst_n(rst_n), .in(in_b), .sticky_clr(clr_b),
        .out(out_b), .rise(rise_b), .fall(fall_b), .sticky_rise(sticky_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        in_m  = 8'hFF; clr_m = 8'h00;
        in_a  = 1'b0;  clr_a = 1'b0;
        in_b  = 32'hFFFF_0000; clr_b = 32'h0;

        // Reset assertion before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_noclk_out", 64'(out_m), 64'h0);
        check("rst_noclk_rise", 64'(rise_m), 64'h0);
        check("rst_noclk_sticky", 64'(sticky_m), 64'h0);
        tick(); tick();
        check("rst_out_w32_init", 64'(out_b), 64'hFFFF_0000);
        check("rst_out_w1", 64'(out_a), 64'h0);
        check("rst_fall_m", 64'(fall_m), 64'h0);

        // Test 1: release with in=FF, INIT_VAL=0 -> out FF at edge 5
        rst_n = 1'b1;
        tick(); tick();
        for (int j = 0; j <= 6; j++) begin
            tick();
            check($sformatf("t1_out_j%0d", j), 64'(out_m), (j >= 5) ? 64'hFF : 64'h0);
            check($sformatf("t1_rise_j%0d", j), 64'(rise_m), (j == 5) ? 64'hFF : 64'h0);
            check($sformatf("t1_fall_j%0d", j), 64'(fall_m), 64'h0);
            check($sformatf("t1_sticky_j%0d", j), 64'(sticky_m), (j >= 5) ? 64'hFF : 64'h0);
        end

        // Bring all channels low, clear all stickies
        for (int j = 0; j <= 6; j++) begin
            in_m  = 8'h00;
            clr_m = (j == 0) ? 8'hFF : 8'h00;
            tick();
            check($sformatf("low_out_j%0d", j), 64'(out_m), (j >= 5) ? 64'h0 : 64'hFF);
            check($sformatf("low_fall_j%0d", j), 64'(fall_m), (j == 5) ? 64'hFF : 64'h0);
            check($sformatf("low_sticky_j%0d", j), 64'(sticky_m), 64'h0);
        end

        // Test 2: 3-cycle excursion on ch3 is rejected
        for (int j = 0; j <= 9; j++) begin
            in_m = (j < 3) ? 8'h08 : 8'h00;
            tick();
            check($sformatf("t2_out_j%0d", j), 64'(out_m), 64'h0);
            check($sformatf("t2_rise_j%0d", j), 64'(rise_m), 64'h0);
            if (j == 4) begin
                check("t2_cnt_peak", 64'(dut.cnt_r[3]), 64'h3);
            end
        end
        check("t2_sticky", 64'(sticky_m), 64'h0);
        check("t2_cnt_zero", 64'(dut.cnt_r[3]), 64'h0);

        // Test 3: 4-cycle pulse on ch3 accepted, then falls
        for (int j = 0; j <= 13; j++) begin
            in_m = (j < 4) ? 8'h08 : 8'h00;
            tick();
            check($sformatf("t3_out_j%0d", j), 64'(out_m), (j >= 5 && j <= 8) ? 64'h08 : 64'h0);
            check($sformatf("t3_rise_j%0d", j), 64'(rise_m), (j == 5) ? 64'h08 : 64'h0);
            check($sformatf("t3_fall_j%0d", j), 64'(fall_m), (j == 9) ? 64'h08 : 64'h0);
        end
        check("t3_sticky", 64'(sticky_m), 64'h08);

        // Test 4: clear on ch2 coincident with its rise, then clear alone
        for (int j = 0; j <= 6; j++) begin
            in_m  = 8'h04;
            clr_m = (j >= 5) ? 8'h04 : 8'h00;
            tick();
            check($sformatf("t4_rise_j%0d", j), 64'(rise_m), (j == 5) ? 64'h04 : 64'h0);
            check($sformatf("t4_sticky_j%0d", j), 64'(sticky_m),
                  (j == 5) ? 64'h0C : 64'h08);
        end
        clr_m = 8'h04;
        tick();
        check("t4_clr_when_zero", 64'(sticky_m), 64'h08);
        clr_m = 8'h00;
        check("t4_out", 64'(out_m), 64'h04);

        // Test 5: async reset while ch5 counter is at 2
        in_m = 8'h24;
        for (int j = 0; j <= 3; j++) begin
            tick();
        end
        check("t5_cnt_before", 64'(dut.cnt_r[5]), 64'h2);
        check("t5_out_before", 64'(out_m), 64'h04);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_out", 64'(out_m), 64'h0);
        check("t5_async_sticky", 64'(sticky_m), 64'h0);
        check("t5_async_rise_fall", 64'({rise_m, fall_m}), 64'h0);
        check("t5_async_cnt", 64'(dut.cnt_r[5]), 64'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        for (int j = 0; j <= 6; j++) begin
            tick();
            check($sformatf("t5_out_j%0d", j), 64'(out_m), (j >= 5) ? 64'h24 : 64'h0);
            check($sformatf("t5_rise_j%0d", j), 64'(rise_m), (j == 5) ? 64'h24 : 64'h0);
        end

        // Test 6: SYNC=8, FILTER=1 -> 8-edge latency, upper bits zero
        in_a = 1'b1;
        in_b = 32'h0000_A5A5;
        for (int j = 0; j <= 9; j++) begin
            tick();
            check($sformatf("t6_w1_out_j%0d", j), 64'(out_a), (j >= 8) ? 64'h1 : 64'h0);
            check($sformatf("t6_w1_rise_j%0d", j), 64'(rise_a), (j == 8) ? 64'h1 : 64'h0);
            check($sformatf("t6_w32_out_j%0d", j), 64'(out_b),
                  (j >= 8) ? 64'h0000_A5A5 : 64'hFFFF_0000);
            check($sformatf("t6_w32_rise_j%0d", j), 64'(rise_b), (j == 8) ? 64'h0000_A5A5 : 64'h0);
            check($sformatf("t6_w32_fall_j%0d", j), 64'(fall_b), (j == 8) ? 64'hFFFF_0000 : 64'h0);
        end
        for (int j = 0; j <= 10; j++) begin
            in_a = (j == 0) ? 1'b0 : 1'b1;
            tick();
            check($sformatf("t6_pulse_out_j%0d", j), 64'(out_a), (j == 8) ? 64'h0 : 64'h1);
            check($sformatf("t6_pulse_fall_j%0d", j), 64'(fall_a), (j == 8) ? 64'h1 : 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
